// File: rtl/riscv_decode_queue.sv
// RV32I decode stage: decodes each fetched word on acceptance and holds the
// decoded bundle plus its PC in a DEPTH-entry queue feeding execute.
module riscv_decode_queue #(
    parameter int unsigned DEPTH        = 4,
    parameter int unsigned PC_WIDTH     = 32,
    parameter int unsigned ALU_OP_WIDTH = 5
) (
    input  logic                    clk_i,
    input  logic                    arstn_i,
    input  logic                    flush_i,
    input  logic                    in_valid_i,
    output logic                    in_ready_o,
    input  logic [31:0]             fetched_instr_i,
    input  logic [PC_WIDTH-1:0]     fetched_pc_i,
    output logic                    out_valid_o,
    input  logic                    out_ready_i,
    output logic [PC_WIDTH-1:0]     pc_o,
    output logic [1:0]              ex_op_a_sel_o,
    output logic [2:0]              ex_op_b_sel_o,
    output logic [31:0]             imm_o,
    output logic [ALU_OP_WIDTH-1:0] alu_op_o,
    output logic                    mem_req_o,
    output logic                    mem_we_o,
    output logic [2:0]              mem_size_o,
    output logic                    gpr_we_a_o,
    output logic                    wb_src_sel_o,
    output logic                    illegal_instr_o,
    output logic                    branch_o,
    output logic                    jal_o,
    output logic                    jalr_o
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

    localparam logic [4:0] ALU_ADD = 5'b00000;
    localparam logic [4:0] ALU_SUB = 5'b01000;
    localparam logic [4:0] ALU_SRL = 5'b00101;
    localparam logic [4:0] ALU_SRA = 5'b01101;

    typedef struct packed {
        logic [PC_WIDTH-1:0]     pc;
        logic [1:0]              op_a_sel;
        logic [2:0]              op_b_sel;
        logic [31:0]             imm;
        logic [ALU_OP_WIDTH-1:0] alu_op;
        logic                    mem_req;
        logic                    mem_we;
        logic [2:0]              mem_size;
        logic                    gpr_we;
        logic                    wb_src_sel;
        logic                    illegal;
        logic                    branch;
        logic                    jal;
        logic                    jalr;
    } entry_t;

    entry_t            mem [DEPTH];
    entry_t            dec;
    entry_t            head;
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;
    logic              full;
    logic              push;
    logic              pop;

    logic [6:0]        opcode;
    logic [2:0]        funct3;
    logic [6:0]        funct7;
    logic [31:0]       imm_i;
    logic [31:0]       imm_s;
    logic [31:0]       imm_b;
    logic [31:0]       imm_u;
    logic [31:0]       imm_j;
    logic [4:0]        alu5;
    logic              illegal;

    assign opcode = fetched_instr_i[6:0];
    assign funct3 = fetched_instr_i[14:12];
    assign funct7 = fetched_instr_i[31:25];

    assign imm_i = {{20{fetched_instr_i[31]}}, fetched_instr_i[31:20]};
    assign imm_s = {{20{fetched_instr_i[31]}}, fetched_instr_i[31:25], fetched_instr_i[11:7]};
    assign imm_b = {{19{fetched_instr_i[31]}}, fetched_instr_i[31], fetched_instr_i[7],
                    fetched_instr_i[30:25], fetched_instr_i[11:8], 1'b0};
    assign imm_u = {fetched_instr_i[31:12], 12'b0};
    assign imm_j = {{11{fetched_instr_i[31]}}, fetched_instr_i[31], fetched_instr_i[19:12],
                    fetched_instr_i[20], fetched_instr_i[30:21], 1'b0};

    // Full decode of the incoming word into a queue entry.
    always_comb begin
        dec     = '0;
        alu5    = ALU_ADD;
        illegal = 1'b0;
        dec.pc  = fetched_pc_i;
        case (opcode)
            OPC_OP: begin
                dec.gpr_we = 1'b1;
                case (funct3)
                    3'd0: begin
                        if (funct7 == 7'h20)      alu5 = ALU_SUB;
                        else if (funct7 != 7'h00) illegal = 1'b1;
                    end
                    3'd5: begin
                        if (funct7 == 7'h00)      alu5 = ALU_SRL;
                        else if (funct7 == 7'h20) alu5 = ALU_SRA;
                        else                      illegal = 1'b1;
                    end
                    default: begin
                        alu5 = {2'b00, funct3};
                        if (funct7 != 7'h00) illegal = 1'b1;
                    end
                endcase
            end
            OPC_OP_IMM: begin
                dec.op_b_sel = 3'd1;
                dec.imm      = imm_i;
                dec.gpr_we   = 1'b1;
                case (funct3)
                    3'd1: begin
                        alu5 = {2'b00, funct3};
                        if (funct7 != 7'h00) illegal = 1'b1;
                    end
                    3'd5: begin
                        if (funct7 == 7'h00)      alu5 = ALU_SRL;
                        else if (funct7 == 7'h20) alu5 = ALU_SRA;
                        else                      illegal = 1'b1;
                    end
                    default: alu5 = {2'b00, funct3};
                endcase
            end
            OPC_LUI: begin
                dec.op_a_sel = 2'd2;
                dec.op_b_sel = 3'd2;
                dec.imm      = imm_u;
                dec.gpr_we   = 1'b1;
            end
            OPC_AUIPC: begin
                dec.op_a_sel = 2'd1;
                dec.op_b_sel = 3'd2;
                dec.imm      = imm_u;
                dec.gpr_we   = 1'b1;
            end
            OPC_LOAD: begin
                dec.op_b_sel   = 3'd1;
                dec.imm        = imm_i;
                dec.mem_req    = 1'b1;
                dec.mem_size   = funct3;
                dec.gpr_we     = 1'b1;
                dec.wb_src_sel = 1'b1;
                if (funct3 == 3'd3 || funct3 == 3'd6 || funct3 == 3'd7) illegal = 1'b1;
            end
            OPC_STORE: begin
                dec.op_b_sel = 3'd3;
                dec.imm      = imm_s;
                dec.mem_req  = 1'b1;
                dec.mem_we   = 1'b1;
                dec.mem_size = funct3;
                if (funct3 > 3'd2) illegal = 1'b1;
            end
            OPC_BRANCH: begin
                dec.imm    = imm_b;
                dec.branch = 1'b1;
                if (funct3 == 3'd2 || funct3 == 3'd3) illegal = 1'b1;
                else                                  alu5 = {2'b11, funct3};
            end
            OPC_JAL: begin
                dec.op_a_sel = 2'd1;
                dec.op_b_sel = 3'd4;
                dec.imm      = imm_j;
                dec.gpr_we   = 1'b1;
                dec.jal      = 1'b1;
            end
            OPC_JALR: begin
                dec.op_a_sel = 2'd1;
                dec.op_b_sel = 3'd4;
                dec.imm      = imm_i;
                dec.gpr_we   = 1'b1;
                dec.jalr     = 1'b1;
                if (funct3 != 3'd0) illegal = 1'b1;
            end
            OPC_MISC_MEM, OPC_SYSTEM: ;
            default: illegal = 1'b1;
        endcase
        if (fetched_instr_i[1:0] != 2'b11) illegal = 1'b1;
        dec.alu_op = ALU_OP_WIDTH'(alu5);
        // Illegal words travel down the queue but carry no side effects.
        if (illegal) begin
            dec.illegal = 1'b1;
            dec.mem_req = 1'b0;
            dec.mem_we  = 1'b0;
            dec.gpr_we  = 1'b0;
            dec.branch  = 1'b0;
            dec.jal     = 1'b0;
            dec.jalr    = 1'b0;
        end
    end

    assign full        = (count == CNT_W'(DEPTH));
    assign out_valid_o = (count != '0);
    assign in_ready_o  = !full || out_ready_i;
    assign push        = in_valid_i && in_ready_o && !flush_i;
    assign pop         = out_valid_o && out_ready_i && !flush_i;

    // Entry storage; contents are only observed while counted as valid.
    always_ff @(posedge clk_i) begin
        if (push) mem[wr_ptr] <= dec;
    end

    // Pointer and occupancy bookkeeping; flush wins over push and pop.
    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Head entry, zeroed whenever nothing is valid.
    always_comb begin
        head = '0;
        if (out_valid_o) head = mem[rd_ptr];
    end

    assign pc_o            = head.pc;
    assign ex_op_a_sel_o   = head.op_a_sel;
    assign ex_op_b_sel_o   = head.op_b_sel;
    assign imm_o           = head.imm;
    assign alu_op_o        = head.alu_op;
    assign mem_req_o       = head.mem_req;
    assign mem_we_o        = head.mem_we;
    assign mem_size_o      = head.mem_size;
    assign gpr_we_a_o      = head.gpr_we;
    assign wb_src_sel_o    = head.wb_src_sel;
    assign illegal_instr_o = head.illegal;
    assign branch_o        = head.branch;
    assign jal_o           = head.jal;
    assign jalr_o          = head.jalr;

endmodule

// File: tb/tb_riscv_decode_queue.sv
// Directed bench for riscv_decode_queue: decode table plus queue corner cases.
module tb_riscv_decode_queue;

    localparam int unsigned DEPTH = 4;

    logic        clk = 1'b0;
    logic        arstn = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] instr = 32'h0;
    logic [31:0] fpc = 32'h0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] pc;
    logic [1:0]  a_sel;
    logic [2:0]  b_sel;
    logic [31:0] imm;
    logic [4:0]  alu_op;
    logic        mem_req, mem_we, gpr_we, wb_src, illegal, branch, jal, jalr;
    logic [2:0]  mem_size;

    int compared = 0;
    int mismatched = 0;

    riscv_decode_queue #(.DEPTH(DEPTH), .PC_WIDTH(32), .ALU_OP_WIDTH(5)) dut (
        .clk_i(clk), .arstn_i(arstn), .flush_i(flush),
        .in_valid_i(in_valid), .in_ready_o(in_ready),
        .fetched_instr_i(instr), .fetched_pc_i(fpc),
        .out_valid_o(out_valid), .out_ready_i(out_ready),
        .pc_o(pc), .ex_op_a_sel_o(a_sel), .ex_op_b_sel_o(b_sel),
        .imm_o(imm), .alu_op_o(alu_op), .mem_req_o(mem_req), .mem_we_o(mem_we),
        .mem_size_o(mem_size), .gpr_we_a_o(gpr_we), .wb_src_sel_o(wb_src),
        .illegal_instr_o(illegal), .branch_o(branch), .jal_o(jal), .jalr_o(jalr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] instr;
        logic [1:0]  a;
        logic [2:0]  b;
        logic [31:0] imm;
        logic [4:0]  alu;
        logic        req;
        logic        we;
        logic [2:0]  size;
        logic        gpr;
        logic        wb;
        logic        ill;
        logic        br;
        logic        jal;
        logic        jalr;
    } vec_t;

    vec_t vecs [21];

    logic [52:0] act_bundle;
    assign act_bundle = {a_sel, b_sel, imm, alu_op, mem_req, mem_we, mem_size,
                         gpr_we, wb_src, illegal, branch, jal, jalr};

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [52:0] exp_bundle;

        //            instr         a     b     imm           alu       req   we    size  gpr   wb    ill   br    jal   jalr
        vecs[0]  = '{32'h003100B3, 2'd0, 3'd0, 32'h00000000, 5'b00000, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{32'h00812283, 2'd0, 3'd1, 32'h00000008, 5'b00000, 1'b1, 1'b0, 3'd2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[2]  = '{32'h010000EF, 2'd1, 3'd4, 32'h00000010, 5'b00000, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[3]  = '{32'h00000000, 2'd0, 3'd0, 32'h00000000, 5'b00000, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[4]  = '{32'h403100B3, 2'd0, 3'd0, 32'h00000000, 5'b01000, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[5]  = '{32'h403150B3, 2'd0, 3'd0, 32'h00000000, 5'b01101, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[6]  = '{32'h023100B3, 2'd0, 3'd0, 32'h00000000, 5'b00000, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[7]  = '{32'hFFF10093, 2'd0, 3'd1, 32'hFFFFFFFF, 5'b00000, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[8]  = '{32'h40315093, 2'd0, 3'd1, 32'h00000403, 5'b01101, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[9]  = '{32'h00512623, 2'd0, 3'd3, 32'h0000000C, 5'b00000, 1'b1, 1'b1, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[10] = '{32'hFE208CE3, 2'd0, 3'd0, 32'hFFFFFFF8, 5'b11000, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[11] = '{32'hFE20FCE3, 2'd0, 3'd0, 32'hFFFFFFF8, 5'b11111, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[12] = '{32'hFE20ACE3, 2'd0, 3'd0, 32'hFFFFFFF8, 5'b00000, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[13] = '{32'h123450B7, 2'd2, 3'd2, 32'h12345000, 5'b00000, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[14] = '{32'h00001097, 2'd1, 3'd2, 32'h00001000, 5'b00000, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[15] = '{32'h004100E7, 2'd1, 3'd4, 32'h00000004, 5'b00000, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[16] = '{32'h004110E7, 2'd1, 3'd4, 32'h00000004, 5'b00000, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[17] = '{32'h00813283, 2'd0, 3'd1, 32'h00000008, 5'b00000, 1'b0, 1'b0, 3'd3, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[18] = '{32'h003100B1, 2'd0, 3'd0, 32'h00000000, 5'b00000, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[19] = '{32'h0000000F, 2'd0, 3'd0, 32'h00000000, 5'b00000, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[20] = '{32'h40311093, 2'd0, 3'd1, 32'h00000403, 5'b00001, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};

        // Reset state
        #2;
        check("reset_valid", 64'(out_valid), 64'd0);
        check("reset_bundle", 64'(act_bundle), 64'd0);
        check("reset_pc", 64'(pc), 64'd0);
        tick();
        arstn = 1'b1;
        #1;
        check("post_reset_ready", 64'(in_ready), 64'd1);

        // Decode table: push one word, check it at the head next cycle, pop it.
        out_ready = 1'b1;
        for (int i = 0; i < 21; i++) begin
            in_valid = 1'b1;
            instr    = vecs[i].instr;
            fpc      = 32'h1000 + 32'(4 * i);
            tick();
            in_valid = 1'b0;
            exp_bundle = {vecs[i].a, vecs[i].b, vecs[i].imm, vecs[i].alu, vecs[i].req,
                          vecs[i].we, vecs[i].size, vecs[i].gpr, vecs[i].wb, vecs[i].ill,
                          vecs[i].br, vecs[i].jal, vecs[i].jalr};
            check($sformatf("vec%0d_valid", i), 64'(out_valid), 64'd1);
            check($sformatf("vec%0d_pc", i), 64'(pc), 64'(32'h1000 + 32'(4 * i)));
            check($sformatf("vec%0d_bundle", i), 64'(act_bundle), 64'(exp_bundle));
        end
        tick();
        check("drained_valid", 64'(out_valid), 64'd0);
        check("drained_bundle", 64'(act_bundle), 64'd0);

        // Fill to DEPTH with execute stalled.
        out_ready = 1'b0;
        instr     = 32'h003100B3;
        for (int i = 0; i < DEPTH; i++) begin
            in_valid = 1'b1;
            fpc      = 32'h100 + 32'(4 * i);
            tick();
        end
        in_valid = 1'b0;
        check("full_ready", 64'(in_ready), 64'd0);
        check("full_valid", 64'(out_valid), 64'd1);
        check("full_head_pc", 64'(pc), 64'h100);

        // Word offered while full must not be taken.
        in_valid = 1'b1;
        fpc      = 32'h999;
        tick();
        check("full_hold_pc", 64'(pc), 64'h100);
        check("full_hold_ready", 64'(in_ready), 64'd0);

        // Push with pop while full, then drain: order must survive the wrap.
        out_ready = 1'b1;
        for (int i = 0; i < 2 * DEPTH; i++) begin
            in_valid = (i < DEPTH);
            fpc      = 32'h100 + 32'(4 * (i + DEPTH));
            #1;
            check($sformatf("wrap%0d_ready", i), 64'(in_ready), 64'd1);
            check($sformatf("wrap%0d_valid", i), 64'(out_valid), 64'd1);
            check($sformatf("wrap%0d_pc", i), 64'(pc), 64'(32'h100 + 32'(4 * i)));
            tick();
        end
        in_valid = 1'b0;
        check("wrap_empty", 64'(out_valid), 64'd0);

        // Flush with three queued entries and a word presented the same cycle.
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            fpc      = 32'h200 + 32'(4 * i);
            tick();
        end
        flush    = 1'b1;
        in_valid = 1'b1;
        fpc      = 32'h300;
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        check("flush_valid", 64'(out_valid), 64'd0);
        check("flush_pc", 64'(pc), 64'd0);
        in_valid  = 1'b1;
        fpc       = 32'h400;
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        check("post_flush_valid", 64'(out_valid), 64'd1);
        check("post_flush_pc", 64'(pc), 64'h400);
        tick();
        check("post_flush_empty", 64'(out_valid), 64'd0);

        // Asynchronous reset mid-stream.
        out_ready = 1'b0;
        instr     = 32'h00812283;
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1;
            fpc      = 32'h500 + 32'(4 * i);
            tick();
        end
        in_valid = 1'b0;
        check("pre_arst_valid", 64'(out_valid), 64'd1);
        #2;
        arstn = 1'b0;
        #1;
        check("arst_valid", 64'(out_valid), 64'd0);
        check("arst_bundle", 64'(act_bundle), 64'd0);
        check("arst_pc", 64'(pc), 64'd0);
        tick();
        arstn = 1'b1;
        tick();
        check("arst_release_valid", 64'(out_valid), 64'd0);
        check("arst_release_ready", 64'(in_ready), 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/riscv_decode_queue.md
Name: riscv_decode_queue

Overview:
- Registered RV32I decode stage with a DEPTH-entry decoded-instruction queue between fetch and execute.
- Each fetched word is fully decoded when it is accepted: control fields, sign-extended immediate and legality.
- The decoded bundle is stored together with its PC, then handed to execute over a valid/ready handshake.
- Supports back-pressure and flush (branch/jump redirect).

Parameters:
- DEPTH, 4, number of queue entries; power of two, >= 2.
- PC_WIDTH, 32, width of the PC carried alongside each instruction.
- ALU_OP_WIDTH, 5, width of the ALU operation code.

Ports:
- clk_i  in  1  clock; all state updates on its rising edge.
- arstn_i  in  1  asynchronous active-low reset.
- flush_i  in  1  discard all queued entries.
- in_valid_i  in  1  fetch has a word.
- in_ready_o  out  1  queue accepts the word this cycle.
- fetched_instr_i  in  32  instruction word.
- fetched_pc_i  in  PC_WIDTH  PC of the instruction word.
- out_valid_o  out  1  head entry valid.
- out_ready_i  in  1  execute consumes the head entry.
- pc_o  out  PC_WIDTH  PC of the head entry.
- ex_op_a_sel_o  out  2  operand A select: 0 = rs1, 1 = PC, 2 = zero.
- ex_op_b_sel_o  out  3  operand B select: 0 = rs2, 1 = imm_I, 2 = imm_U, 3 = imm_S, 4 = constant 4.
- imm_o  out  32  sign-extended immediate for the instruction's format (I/S/B/U/J).
- alu_op_o  out  ALU_OP_WIDTH  ALU operation code.
- mem_req_o  out  1  memory request.
- mem_we_o  out  1  memory write enable.
- mem_size_o  out  3  memory access size (funct3).
- gpr_we_a_o  out  1  register-file write enable.
- wb_src_sel_o  out  1  write-back source: 0 = ALU, 1 = memory.
- illegal_instr_o  out  1  instruction is illegal.
- branch_o  out  1  conditional branch.
- jal_o  out  1  JAL.
- jalr_o  out  1  JALR.

Behaviour:
- Reset (arstn_i low, asynchronous): pointers and count cleared.
  - out_valid_o = 0.
  - All decoded outputs and pc_o = 0.
  - in_ready_o = 1 after reset releases.
- Decoded outputs and pc_o are forced to 0 whenever out_valid_o = 0.
- Handshake:
  - Push occurs when in_valid_i && in_ready_o.
  - Pop occurs when out_valid_o && out_ready_i.
  - in_ready_o = !full || out_ready_i; when full, a push is allowed in the same cycle as a pop.
  - Latency: an accepted word appears at the head in the next cycle if the queue was empty. No combinational path from fetched_instr_i to any output.
- Simultaneous push and pop: count unchanged, both pointers advance.
- Pointers wrap modulo DEPTH.
- Full:
  - Push without a pop is impossible, because in_ready_o = 0.
  - No entry is ever overwritten.
- Empty:
  - Pop is impossible.
  - Empty plus push: out_valid_o goes high in the next cycle.
- flush_i has priority over push and pop in the same cycle.
  - Next cycle: count = 0 and out_valid_o = 0.
  - A word presented during a flush cycle is dropped, even if in_ready_o was high.
- Decode at push. Unlisted fields are 0; all ALU ops below are ADD unless stated.
  - OP: a=0, b=0, gpr_we=1.
    - funct3 0 / 5: funct7 0x00 selects ADD / SRL; 0x20 selects SUB / SRA.
    - Other funct3 require funct7 = 0x00: 1 SLL, 2 LTS, 3 LTU, 4 XOR, 6 OR, 7 AND.
  - OP_IMM: a=0, b=1, gpr_we=1, same mapping as OP.
    - funct3 1 requires funct7 = 0x00.
    - funct3 5: funct7 0x00 selects SRL, 0x20 selects SRA.
  - LUI: a=2, b=2, gpr_we=1.
  - AUIPC: a=1, b=2, gpr_we=1.
  - LOAD: a=0, b=1, mem_req=1, mem_we=0, mem_size=funct3, gpr_we=1, wb_src=1. Legal funct3: 0, 1, 2, 4, 5.
  - STORE: a=0, b=3, mem_req=1, mem_we=1, mem_size=funct3. Legal funct3: 0, 1, 2.
  - BRANCH: a=0, b=0, branch=1.
    - funct3 0 EQ (11000), 1 NE (11001), 4 LTS (11100), 5 GES (11101), 6 LTU (11110), 7 GEU (11111).
    - funct3 2, 3 are illegal.
  - JAL: a=1, b=4, gpr_we=1, jal=1.
  - JALR: a=1, b=4, gpr_we=1, jalr=1. Requires funct3 = 0.
  - MISC_MEM, SYSTEM: no side effects, legal.
- Illegal instruction: any of the following.
  - instr[1:0] != 2'b11.
  - Unknown opcode.
  - Any violated funct rule above.
- Illegal entries: illegal_instr_o = 1; mem_req, mem_we, gpr_we, branch, jal, jalr are forced to 0. The entry is still queued and popped normally.
- ALU op codes: ADD 00000, SUB 01000, SLL 00001, LTS 00010, LTU 00011, XOR 00100, SRL 00101, SRA 01101, OR 00110, AND 00111.

Test Plan:
- Reset, then push 0x003100B3 (ADD x1,x2,x3) -> next cycle out_valid=1, alu_op=00000, a=0, b=0, gpr_we=1, illegal=0.
- Push 0x00812283 (LW x5,8(x2)) -> mem_req=1, mem_we=0, mem_size=2, wb_src=1, b=1, imm_o=8.
- Push 0x010000EF (JAL x1,+16) -> jal=1, a=1, b=4, imm_o=16. Push 0x00000000 -> illegal=1, gpr_we=0, mem_req=0.
- Fill with out_ready=0 -> after DEPTH pushes in_ready=0 and count=DEPTH. Raise out_ready with in_valid=1 -> in_ready=1, push and pop in the same cycle, FIFO order preserved across the pointer wrap.
- Queue holding 3 entries, assert flush_i together with in_valid=1 -> next cycle out_valid=0 and the presented word is absent from later output.
- Assert arstn_i low asynchronously mid-stream -> out_valid and all outputs 0 immediately, queue empty after release.
